// File: rtl/delay_commutator.sv
// delay_commutator: radix-2 delay-commutator stage for a streaming FFT.
// Lane 1 is delayed by DEPTH accepted samples, a toggle that flips every
// DEPTH accepted samples swaps which lane feeds the second DEPTH-sample delay,
// and both results leave through a registered output stage.
// Optional feature: define DELAY_COMM_FLUSH_EN to add the synchronous flush port.
module delay_commutator #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DELAY_COMM_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_0_re,
    input  logic [DATA_W-1:0] in_0_im,
    input  logic [DATA_W-1:0] in_1_re,
    input  logic [DATA_W-1:0] in_1_im,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_0_re,
    output logic [DATA_W-1:0] out_0_im,
    output logic [DATA_W-1:0] out_1_re,
    output logic [DATA_W-1:0] out_1_im
);

    // Switch counter needs at least one bit even when DEPTH is 1.
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Fill counter must be able to hold the value DEPTH itself.
    localparam int FW = $clog2(DEPTH + 1);
    // Real and imaginary parts travel together as one packed word {re, im}.
    localparam int SW = 2 * DATA_W;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [SW-1:0] d1_q [DEPTH];   // lane-1 delay line, entry DEPTH-1 is oldest
    logic [SW-1:0] da_q [DEPTH];   // A-path delay line, entry DEPTH-1 is oldest

    logic [CW-1:0] cnt_q,  cnt_d;
    logic          tog_q,  tog_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out0_q, out0_d;
    logic [SW-1:0] out1_q, out1_d;

    logic [SW-1:0] in0_s;
    logic [SW-1:0] in1_s;
    logic [SW-1:0] d1_out_s;
    logic [SW-1:0] a_s;
    logic [SW-1:0] b_s;
    logic          flush_s;
    logic          accept_s;

    assign in0_s    = {in_0_re, in_0_im};
    assign in1_s    = {in_1_re, in_1_im};
    assign d1_out_s = d1_q[DEPTH-1];

`ifdef DELAY_COMM_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // A flushed sample is discarded, so it must not enter the delay lines.
    assign accept_s = in_valid & ~flush_s;

    // Commutator: the toggle selects which lane feeds the A delay path.
    always_comb begin
        a_s = in0_s;
        b_s = d1_out_s;
        if (tog_q) begin
            a_s = d1_out_s;
            b_s = in0_s;
        end else begin
            a_s = in0_s;
            b_s = d1_out_s;
        end
    end

    // Next-state for counters, toggle and the registered output stage.
    always_comb begin
        cnt_d       = cnt_q;
        tog_d       = tog_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out0_d      = out0_q;
        out1_d      = out1_q;
        if (flush_s) begin
            cnt_d       = {CW{1'b0}};
            tog_d       = 1'b0;
            fill_d      = {FW{1'b0}};
            out_valid_d = 1'b0;
        end else if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
                tog_d = ~tog_q;
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                tog_d = tog_q;
            end
            if (fill_q == FILL_MAX) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + {{(FW-1){1'b0}}, 1'b1};
            end
            // Fill count before this sample equals min(k, DEPTH).
            out_valid_d = (fill_q == FILL_MAX);
            out0_d      = da_q[DEPTH-1];
            out1_d      = b_s;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers; reset beats flush and in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CW{1'b0}};
            tog_q       <= 1'b0;
            fill_q      <= {FW{1'b0}};
            out_valid_q <= 1'b0;
            out0_q      <= {SW{1'b0}};
            out1_q      <= {SW{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            tog_q       <= tog_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
        end
    end

    // Both delay lines shift only on accepted samples and survive a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d1_q[i] <= {SW{1'b0}};
                da_q[i] <= {SW{1'b0}};
            end
        end else if (accept_s) begin
            d1_q[0] <= in1_s;
            da_q[0] <= a_s;
            for (int i = 1; i < DEPTH; i++) begin
                d1_q[i] <= d1_q[i-1];
                da_q[i] <= da_q[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                d1_q[i] <= d1_q[i];
                da_q[i] <= da_q[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_0_re  = out0_q[SW-1:DATA_W];
    assign out_0_im  = out0_q[DATA_W-1:0];
    assign out_1_re  = out1_q[SW-1:DATA_W];
    assign out_1_im  = out1_q[DATA_W-1:0];

endmodule

// File: tb/tb_delay_commutator.sv
// Bench for delay_commutator: three instances (DEPTH 1, 2, 4) share one
// input stream and are compared every cycle against a history-based model.
// Flush stimulus is included when DELAY_COMM_FLUSH_EN is defined.
module tb_delay_commutator;

    localparam int DW = 16;
    localparam int NI = 3;
    localparam int HN = 2048;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_0_re, in_0_im, in_1_re, in_1_im;

    logic          ov  [NI];
    logic [DW-1:0] o0r [NI];
    logic [DW-1:0] o0i [NI];
    logic [DW-1:0] o1r [NI];
    logic [DW-1:0] o1i [NI];

    int total;
    int bad;

    // Model state: history of accepted lane-1 inputs and A values since reset.
    int            dep [NI];
    logic [31:0]   h1  [NI][HN];
    logic [31:0]   ha  [NI][HN];
    int            hn  [NI];
    int            kc  [NI];
    logic          ev  [NI];
    logic [31:0]   eo0 [NI];
    logic [31:0]   eo1 [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    delay_commutator #(.DATA_W(DW), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst),
`ifdef DELAY_COMM_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_0_re(in_0_re), .in_0_im(in_0_im), .in_1_re(in_1_re), .in_1_im(in_1_im),
        .out_valid(ov[0]), .out_0_re(o0r[0]), .out_0_im(o0i[0]),
        .out_1_re(o1r[0]), .out_1_im(o1i[0])
    );

    delay_commutator #(.DATA_W(DW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst),
`ifdef DELAY_COMM_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_0_re(in_0_re), .in_0_im(in_0_im), .in_1_re(in_1_re), .in_1_im(in_1_im),
        .out_valid(ov[1]), .out_0_re(o0r[1]), .out_0_im(o0i[1]),
        .out_1_re(o1r[1]), .out_1_im(o1i[1])
    );

    delay_commutator #(.DATA_W(DW), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst),
`ifdef DELAY_COMM_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_0_re(in_0_re), .in_0_im(in_0_im), .in_1_re(in_1_re), .in_1_im(in_1_im),
        .out_valid(ov[2]), .out_0_re(o0r[2]), .out_0_im(o0i[2]),
        .out_1_re(o1r[2]), .out_1_im(o1i[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: k counts accepted samples since reset/flush; pattern is
    // floor(k/D) mod 2; D1(k)=in_1(k-D); out_0=A(k-D); out_1=B(k).
    task automatic model_update();
        logic [31:0] in0, in1, d1, a, b;
        int d;
        in0 = {in_0_re, in_0_im};
        in1 = {in_1_re, in_1_im};
        for (int i = 0; i < NI; i++) begin
            d = dep[i];
            if (rst) begin
                hn[i]  = 0;
                kc[i]  = 0;
                ev[i]  = 1'b0;
                eo0[i] = 32'h0;
                eo1[i] = 32'h0;
            end else if (flush) begin
                kc[i] = 0;
                ev[i] = 1'b0;
            end else if (in_valid) begin
                d1 = (hn[i] >= d) ? h1[i][hn[i]-d] : 32'h0;
                if (((kc[i] / d) % 2) == 1) begin
                    a = d1;
                    b = in0;
                end else begin
                    a = in0;
                    b = d1;
                end
                eo0[i] = (hn[i] >= d) ? ha[i][hn[i]-d] : 32'h0;
                eo1[i] = b;
                ev[i]  = (kc[i] >= d);
                h1[i][hn[i]] = in1;
                ha[i][hn[i]] = a;
                hn[i] = hn[i] + 1;
                kc[i] = kc[i] + 1;
            end else begin
                ev[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("valid_D%0d", dep[i]), {63'h0, ov[i]}, {63'h0, ev[i]});
            check_eq($sformatf("out0_D%0d", dep[i]), {32'h0, o0r[i], o0i[i]}, {32'h0, eo0[i]});
            check_eq($sformatf("out1_D%0d", dep[i]), {32'h0, o1r[i], o1i[i]}, {32'h0, eo1[i]});
        end
    endtask

    // One clock: drive at negedge, let the DUT sample, then compare after the edge.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [DW-1:0] a_re, input logic [DW-1:0] b_re);
        @(negedge clk);
        rst      = r;
        flush    = f;
        in_valid = v;
        in_0_re  = a_re;
        in_0_im  = a_re + 16'd1000;
        in_1_re  = b_re;
        in_1_im  = b_re + 16'd1000;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        logic f;
        total = 0;
        bad   = 0;
        dep[0] = 1; dep[1] = 2; dep[2] = 4;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_0_re = 16'h0; in_0_im = 16'h0; in_1_re = 16'h0; in_1_im = 16'h0;

        // Reset with a sample presented: it must be discarded.
        step(1'b1, 1'b0, 1'b1, 16'd55, 16'd66);
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);

        // Back-to-back k=0..15.
        for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));

        // Gap between every sample after a fresh reset.
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));
            step(1'b0, 1'b0, 1'b0, 16'(777), 16'(888));
        end

        // Mid-stream reset after six accepted samples, then restart.
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));
        step(1'b1, 1'b0, 1'b1, 16'd9, 16'd9);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));

`ifdef DELAY_COMM_FLUSH_EN
        // Flush together with a valid sample after k=3.
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));
        step(1'b0, 1'b1, 1'b1, 16'd50, 16'd150);
        for (int k = 4; k < 10; k++) step(1'b0, 1'b0, 1'b1, 16'(k), 16'(100 + k));
        // Reset wins over flush.
        step(1'b1, 1'b1, 1'b1, 16'd1, 16'd2);
`endif

        // Randomized traffic with occasional reset and flush.
        for (int n = 0; n < 600; n++) begin
            f = 1'b0;
`ifdef DELAY_COMM_FLUSH_EN
            f = ($urandom_range(0, 29) == 0);
`endif
            step(($urandom_range(0, 79) == 0), f, ($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
